// File: rtl/cp0_regfile_if.sv
// CP0 register-file bus: WB-stage mtc0 write, combinational read port and
// the precise exception / eret commit group.
interface cp0_regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;

  modport master (
    output we, waddr, wdata, raddr,
    output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    input  rdata
  );

  modport slave (
    input  we, waddr, wdata, raddr,
    input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    output rdata
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: mtc0/exception/eret commit, Count/Compare timer,
// hardware interrupt sampling and the interrupt request to the exception unit.
module cp0_regfile #(
  parameter int COUNT_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  cp0_regfile_if.slave       bus,
  input  logic [5:0]         int_i,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic               int_req,
  output logic               timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        div_q, div_d;
  logic        tick;

  assign tick = (div_q == 1'(COUNT_DIV - 1));

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = tick ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q | (count_q == compare_q);
    ip_hw_d    = {int_i[5] | ti_q, int_i[4:0]};
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    div_d      = tick ? 1'b0 : div_q + 1'b1;

    // Exception beats eret beats mtc0; the losers are dropped entirely.
    if (bus.exc_valid) begin
      exl_d     = 1'b1;
      exccode_d = bus.exc_code;
      if (!exl_q) begin
        epc_d = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        bd_d  = bus.exc_bd;
      end
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) begin
        badvaddr_d = bus.exc_badvaddr;
      end
    end else if (bus.eret) begin
      exl_d = 1'b0;
    end else if (bus.we) begin
      case (bus.waddr)
        REG_COUNT:   count_d = bus.wdata;
        REG_COMPARE: begin
          compare_d = bus.wdata;
          ti_d      = 1'b0;
        end
        REG_STATUS:  begin
          im_d  = bus.wdata[15:8];
          exl_d = bus.wdata[1];
          ie_d  = bus.wdata[0];
        end
        REG_CAUSE:   ip_sw_d = bus.wdata[9:8];
        REG_EPC:     epc_d   = bus.wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      div_q      <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      div_q      <= div_d;
    end
  end

  // BEV is hard-wired to 1; every unimplemented field reads as 0.
  assign status_o    = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_o     = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
  assign epc_o       = epc_q;
  assign timer_int_o = ti_q;
  assign int_req     = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      REG_BADVADDR: bus.rdata = badvaddr_q;
      REG_COUNT:    bus.rdata = count_q;
      REG_COMPARE:  bus.rdata = compare_q;
      REG_STATUS:   bus.rdata = status_o;
      REG_CAUSE:    bus.rdata = cause_o;
      REG_EPC:      bus.rdata = epc_q;
      default:      bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: directed commits push expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic [31:0] status_o, cause_o, epc_o;
  logic        int_req, timer_int_o;

  cp0_regfile_if bus();

  cp0_regfile #(.COUNT_DIV(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .int_i       (int_i),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .int_req     (int_req),
    .timer_int_o (timer_int_o)
  );

  always #5 clk = ~clk;

  localparam int S_RDATA = 0, S_STATUS = 1, S_CAUSE = 2, S_EPC = 3, S_IRQ = 4, S_TI = 5;

  typedef struct {
    int          tgt;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   neg_cnt  = 0;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_RDATA:  return bus.rdata;
      S_STATUS: return status_o;
      S_CAUSE:  return cause_o;
      S_EPC:    return epc_o;
      S_IRQ:    return {31'b0, int_req};
      default:  return {31'b0, timer_int_o};
    endcase
  endfunction

  // Monitor: compare every entry due at this negedge.
  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    neg_cnt++;
    while (sbq.size() > 0 && sbq[0].tgt <= neg_cnt) begin
      e   = sbq.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input int sel, input logic [31:0] v, input string nm);
    sbq.push_back('{neg_cnt + 1, sel, v, nm});
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
    bus.raddr = a;
    sbq.push_back('{neg_cnt + 1, S_RDATA, v, nm});
    @(negedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic [31:0] bva);
    bus.exc_valid = 1'b1; bus.exc_code = code; bus.exc_pc = pc;
    bus.exc_bd = bd; bus.exc_badvaddr = bva;
    tick();
    bus.exc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_i = '0;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    bus.exc_valid = 1'b0; bus.exc_code = '0; bus.exc_pc = '0;
    bus.exc_bd = 1'b0; bus.exc_badvaddr = '0; bus.eret = 1'b0;

    tick(2);
    rst = 1'b0;
    expect_o(S_STATUS, 32'h0040_0000, "rst_status");
    expect_o(S_CAUSE,  32'h0,         "rst_cause");
    expect_o(S_EPC,    32'h0,         "rst_epc");
    expect_o(S_IRQ,    32'h0,         "rst_int_req");
    expect_o(S_TI,     32'h0,         "rst_ti");
    rd(5'd9, 32'h0, "rst_count");

    // Timer: Compare=5, Count ticks on every second edge.
    mtc0(5'd11, 32'd5);
    tick(8);
    expect_o(S_TI, 32'h0, "ti_before_match");
    rd(5'd9, 32'd4, "count_4");
    tick();
    expect_o(S_TI, 32'h0, "ti_at_match_cycle");
    rd(5'd9, 32'd5, "count_5");
    tick();
    expect_o(S_TI,    32'h1,         "ti_set");
    expect_o(S_CAUSE, 32'h4000_0000, "cause_ti");
    tick();
    expect_o(S_CAUSE, 32'h4000_8000, "cause_ti_ip7");
    mtc0(5'd11, 32'h100);
    expect_o(S_TI,    32'h0,         "ti_clear");
    expect_o(S_CAUSE, 32'h0000_8000, "cause_ip7_lag");
    tick();
    expect_o(S_CAUSE, 32'h0, "cause_clear");
    rd(5'd11, 32'h100, "compare_rd");
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, 32'hFFFF_FFFF, "count_load");
    tick();
    rd(5'd9, 32'h0, "count_wrap");

    // Exceptions.
    mtc0(5'd12, 32'h0000_FF01);
    expect_o(S_STATUS, 32'h0040_FF01, "status_wr");
    exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h1233);
    expect_o(S_EPC,    32'hBFC0_0100, "exc_bd_epc");
    expect_o(S_STATUS, 32'h0040_FF03, "exc_exl");
    expect_o(S_CAUSE,  32'h8000_0010, "exc_cause");
    expect_o(S_IRQ,    32'h0,         "exc_no_irq");
    rd(5'd8, 32'h1233, "badvaddr");
    exc(5'd8, 32'h8000_0000, 1'b0, 32'h5555);
    expect_o(S_EPC,   32'hBFC0_0100, "nested_epc");
    expect_o(S_CAUSE, 32'h8000_0020, "nested_cause");
    rd(5'd8, 32'h1233, "nested_badvaddr");
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    expect_o(S_STATUS, 32'h0040_FF01, "eret_status");

    // Priority: exception beats eret and mtc0 EPC.
    bus.eret = 1'b1; bus.we = 1'b1; bus.waddr = 5'd14; bus.wdata = 32'hDEAD_BEEF;
    exc(5'd12, 32'h8000_0100, 1'b0, 32'h0);
    bus.eret = 1'b0; bus.we = 1'b0;
    expect_o(S_STATUS, 32'h0040_FF03, "prio_status");
    expect_o(S_EPC,    32'h8000_0100, "prio_epc");
    expect_o(S_CAUSE,  32'h0000_0030, "prio_cause");
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;

    // Interrupts.
    mtc0(5'd12, 32'h0000_0401);
    expect_o(S_STATUS, 32'h0040_0401, "irq_status");
    int_i = 6'b000001;
    expect_o(S_IRQ, 32'h0, "irq_same_cycle");
    tick();
    expect_o(S_CAUSE, 32'h0000_0430, "irq_ip10");
    expect_o(S_IRQ,   32'h1,         "irq_req");
    mtc0(5'd12, 32'h0000_0403);
    expect_o(S_IRQ, 32'h0, "irq_masked_exl");
    mtc0(5'd12, 32'h0000_0401);
    expect_o(S_IRQ, 32'h1, "irq_unmasked");
    int_i = '0;
    tick();
    expect_o(S_IRQ,   32'h0,         "irq_drop");
    expect_o(S_CAUSE, 32'h0000_0030, "irq_cause_drop");
    mtc0(5'd12, 32'h0000_0101);
    mtc0(5'd13, 32'hFFFF_FFFF);
    expect_o(S_CAUSE, 32'h0000_0330, "cause_wr_mask");
    expect_o(S_IRQ,   32'h1,         "sw_irq");
    mtc0(5'd12, 32'hFFFF_FFFF);
    expect_o(S_STATUS, 32'h0040_FF03, "status_wr_mask");
    expect_o(S_IRQ,    32'h0,         "sw_irq_exl");
    mtc0(5'd14, 32'hCAFE_F00D);
    expect_o(S_EPC, 32'hCAFE_F00D, "epc_wr");
    mtc0(5'd15, 32'h1234_5678);
    rd(5'd15, 32'h0, "unmapped_rd");

    // Reset mid-operation overrides a simultaneous exception.
    rst = 1'b1;
    exc(5'd4, 32'h1000_0004, 1'b1, 32'h77);
    rst = 1'b0;
    expect_o(S_STATUS, 32'h0040_0000, "rst2_status");
    expect_o(S_CAUSE,  32'h0,         "rst2_cause");
    expect_o(S_EPC,    32'h0,         "rst2_epc");
    rd(5'd8, 32'h0, "rst2_badvaddr");

    tick(2);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      failures += sbq.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
